// File: rtl/mc_cpu_ctrl_pkg.sv
// Shared definitions for the multi-cycle CPU controller: state codes, opcodes,
// the canonical NOP and the opcode-class helper used by the control FSM.
package mc_cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  // Width of the bus wait counter; BUS_TIMEOUT must fit in it.
  localparam int WAIT_W = 16;

  typedef enum logic [1:0] {
    CLS_RETIRE,
    CLS_WB,
    CLS_LOAD,
    CLS_STORE
  } op_class_t;

  // Branches and unknown opcodes both finish in EXEC.
  function automatic op_class_t classify(input logic [6:0] op);
    case (op)
      OP_LOAD:  return CLS_LOAD;
      OP_STORE: return CLS_STORE;
      OP_OP, OP_OP_IMM, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: return CLS_WB;
      default:  return CLS_RETIRE;
    endcase
  endfunction

endpackage

// File: rtl/mc_cpu_ctrl_bus_wait_timer.sv
// Counts data-bus wait cycles and flags when the configured limit is hit.
// A zero limit never expires.
module bus_wait_timer
  import mc_cpu_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              enable,
  input  logic [WAIT_W-1:0] limit,
  output logic              expired
);

  logic [WAIT_W-1:0] count_reg;

  assign expired = (limit != '0) && (count_reg == limit);

  // Saturate so a disabled timeout cannot wrap around during a long stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && !expired && (count_reg != '1)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/mc_cpu_ctrl.sv
// Multi-cycle CPU control unit: FETCH/DECODE/EXEC/MEM/WB sequencer driving
// datapath enables, the data-bus handshake and the retire/PC update.
module mc_cpu_ctrl
  import mc_cpu_ctrl_pkg::*;
#(
  parameter int          ADDR_W      = 14,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          BUS_TIMEOUT = 15
) (
  input  logic              cpu_clk,
  input  logic              cpu_rst,
  input  logic              halt,
  input  logic [31:0]       inst,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic [31:0]       npc,
  output logic [31:0]       pc,
  output logic [31:0]       ir,
  output logic [2:0]        state,
  output logic              c_we,
  output logic              mdr_we,
  output logic              rf_we,
  output logic              pc_we,
  output logic              bus_req,
  output logic              bus_wen,
  input  logic              bus_ready,
  output logic              bus_err,
  output logic              instret
);

  state_t      state_reg, state_next;
  logic [31:0] pc_reg;
  logic [31:0] ir_reg;
  logic        retire;
  logic        timer_clear;
  logic        timer_en;
  logic        timer_expired;
  op_class_t   ir_class;

  assign ir_class  = classify(ir_reg[6:0]);
  assign pc        = pc_reg;
  assign ir        = ir_reg;
  assign state     = state_reg;
  assign inst_addr = pc_reg[ADDR_W+1:2];

  bus_wait_timer u_wait (
    .clk     (cpu_clk),
    .rst     (cpu_rst),
    .clear   (timer_clear),
    .enable  (timer_en),
    .limit   (WAIT_W'(BUS_TIMEOUT)),
    .expired (timer_expired)
  );

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      state_reg <= ST_FETCH;
      pc_reg    <= RESET_PC;
      ir_reg    <= NOP_INST;
    end else begin
      state_reg <= state_next;
      if (pc_we) pc_reg <= npc;
      if (state_reg == ST_FETCH && !halt) ir_reg <= inst;
    end
  end

  always_comb begin
    state_next  = state_reg;
    c_we        = 1'b0;
    mdr_we      = 1'b0;
    rf_we       = 1'b0;
    bus_req     = 1'b0;
    bus_wen     = 1'b0;
    bus_err     = 1'b0;
    retire      = 1'b0;
    timer_clear = (state_reg != ST_MEM);
    timer_en    = 1'b0;

    case (state_reg)
      ST_FETCH: begin
        if (!halt) state_next = ST_DECODE;
      end
      ST_DECODE: begin
        state_next = ST_EXEC;
      end
      ST_EXEC: begin
        c_we = 1'b1;
        case (ir_class)
          CLS_LOAD, CLS_STORE: state_next = ST_MEM;
          CLS_WB:              state_next = ST_WB;
          default:             retire     = 1'b1;
        endcase
      end
      ST_MEM: begin
        bus_wen  = (ir_class == CLS_STORE);
        timer_en = !bus_ready;
        // A ready in the timeout cycle still completes the transfer normally.
        if (bus_ready) begin
          bus_req = 1'b1;
          if (ir_class == CLS_STORE) begin
            retire = 1'b1;
          end else begin
            mdr_we     = 1'b1;
            state_next = ST_WB;
          end
        end else if (timer_expired) begin
          bus_err = 1'b1;
          retire  = 1'b1;
        end else begin
          bus_req = 1'b1;
        end
      end
      ST_WB: begin
        rf_we  = 1'b1;
        retire = 1'b1;
      end
      default: begin
        state_next = ST_FETCH;
      end
    endcase

    pc_we   = retire;
    instret = retire;
    if (retire) state_next = ST_FETCH;
  end

endmodule

// File: tb/tb_mc_cpu_ctrl.sv
// Self-checking bench for mc_cpu_ctrl: directed scenarios plus random instruction
// streams, each instruction expanded into its expected cycle plan before driving.
module tb_mc_cpu_ctrl;

  localparam int          ADDR_W   = 14;
  localparam logic [31:0] RST_PC   = 32'h0000_0100;
  localparam int          TIMEOUT  = 15;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  logic              cpu_clk;
  logic              cpu_rst;
  logic              halt;
  logic [31:0]       inst;
  logic [ADDR_W-1:0] inst_addr;
  logic [31:0]       npc;
  logic [31:0]       pc;
  logic [31:0]       ir;
  logic [2:0]        state;
  logic              c_we, mdr_we, rf_we, pc_we;
  logic              bus_req, bus_wen, bus_ready, bus_err, instret;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] model_pc;
  logic [31:0] model_ir;

  mc_cpu_ctrl #(
    .ADDR_W      (ADDR_W),
    .RESET_PC    (RST_PC),
    .BUS_TIMEOUT (TIMEOUT)
  ) dut (
    .cpu_clk   (cpu_clk),
    .cpu_rst   (cpu_rst),
    .halt      (halt),
    .inst      (inst),
    .inst_addr (inst_addr),
    .npc       (npc),
    .pc        (pc),
    .ir        (ir),
    .state     (state),
    .c_we      (c_we),
    .mdr_we    (mdr_we),
    .rf_we     (rf_we),
    .pc_we     (pc_we),
    .bus_req   (bus_req),
    .bus_wen   (bus_wen),
    .bus_ready (bus_ready),
    .bus_err   (bus_err),
    .instret   (instret)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  // One expected cycle of an instruction.
  typedef struct {
    logic [2:0] st;
    logic cwe, mwe, rwe, req, wen, err, ret;
    logic hlt, rdy, fet;
  } cyc_t;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_cycle(input string where, input cyc_t c);
    chk({where, " state"},   32'(state),   32'(c.st));
    chk({where, " c_we"},    32'(c_we),    32'(c.cwe));
    chk({where, " mdr_we"},  32'(mdr_we),  32'(c.mwe));
    chk({where, " rf_we"},   32'(rf_we),   32'(c.rwe));
    chk({where, " pc_we"},   32'(pc_we),   32'(c.ret));
    chk({where, " instret"}, 32'(instret), 32'(c.ret));
    chk({where, " bus_req"}, 32'(bus_req), 32'(c.req));
    chk({where, " bus_wen"}, 32'(bus_wen), 32'(c.wen));
    chk({where, " bus_err"}, 32'(bus_err), 32'(c.err));
    chk({where, " pc"},      pc,           model_pc);
    chk({where, " ir"},      ir,           model_ir);
    chk({where, " inst_addr"}, 32'(inst_addr), 32'(model_pc[ADDR_W+1:2]));
  endtask

  // kind: 0 = finishes in EXEC, 1 = goes to WB, 2 = load, 3 = store
  function automatic int op_kind(input logic [6:0] op);
    case (op)
      7'b0000011: return 2;
      7'b0100011: return 3;
      7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111: return 1;
      default: return 0;
    endcase
  endfunction

  // hcyc halted FETCH cycles first; bus_ready rises after d MEM wait cycles.
  task automatic run_inst(input string name, input logic [31:0] instr,
                          input logic [31:0] nv, input int hcyc, input int d,
                          output int ncyc);
    cyc_t q[$];
    cyc_t c;
    int   kind;
    kind = op_kind(instr[6:0]);
    for (int i = 0; i < hcyc; i++) begin
      c = '{default: '0}; c.st = 3'd0; c.hlt = 1'b1; q.push_back(c);
    end
    c = '{default: '0}; c.st = 3'd0; c.fet = 1'b1; q.push_back(c);
    c = '{default: '0}; c.st = 3'd1; q.push_back(c);
    c = '{default: '0}; c.st = 3'd2; c.cwe = 1'b1; c.ret = (kind == 0); q.push_back(c);
    if (kind >= 2) begin
      for (int k = 0; ; k++) begin
        c = '{default: '0}; c.st = 3'd3; c.wen = (kind == 3); c.rdy = (k >= d);
        if (c.rdy) begin
          c.req = 1'b1;
          if (kind == 2) c.mwe = 1'b1; else c.ret = 1'b1;
          q.push_back(c);
          if (kind == 2) kind = 1;
          break;
        end else if (k == TIMEOUT) begin
          c.err = 1'b1; c.ret = 1'b1; q.push_back(c);
          break;
        end else begin
          c.req = 1'b1; q.push_back(c);
        end
      end
    end
    if (kind == 1) begin
      c = '{default: '0}; c.st = 3'd4; c.rwe = 1'b1; c.ret = 1'b1; q.push_back(c);
    end
    ncyc = q.size() - hcyc;
    for (int i = 0; i < q.size(); i++) begin
      c = q[i];
      if (c.st == 3'd0) halt = c.hlt;
      else halt = 1'($urandom);
      bus_ready = (c.st == 3'd3) ? c.rdy : 1'($urandom);
      inst      = c.fet ? instr : $urandom;
      npc       = c.ret ? nv : $urandom;
      #1;
      chk_cycle($sformatf("%s c%0d", name, i), c);
      @(posedge cpu_clk); #1;
      if (c.fet) model_ir = instr;
      if (c.ret) model_pc = nv;
    end
    $display("[TB] %s inst=%h cycles=%0d halted=%0d pc=%h", name, instr, ncyc, hcyc, pc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ncyc;
    logic [6:0]  op;
    logic [31:0] rinst;
    logic [6:0]  ops [9];
    ops = '{7'b0000011, 7'b0100011, 7'b1100011, 7'b0110011, 7'b0010011,
            7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111};

    cpu_rst = 1'b1; halt = 1'b0; inst = '0; npc = '0; bus_ready = 1'b0;
    model_pc = RST_PC; model_ir = NOP_WORD;
    @(posedge cpu_clk); #1;
    chk("reset state", 32'(state), 32'd0);
    chk("reset pc", pc, RST_PC);
    chk("reset ir", ir, NOP_WORD);
    chk("reset enables", {24'd0, c_we, mdr_we, rf_we, pc_we, bus_req, bus_wen, bus_err, instret}, 32'd0);
    @(posedge cpu_clk); #1;
    cpu_rst = 1'b0;

    run_inst("addi", 32'h0010_0093, 32'h0000_0004, 0, 0, ncyc);
    chk("addi cycles", 32'(ncyc), 32'd4);
    chk("addi pc", pc, 32'h0000_0004);
    run_inst("load_wait3", 32'h0000_A103, 32'h0000_0008, 0, 3, ncyc);
    chk("load_wait3 cycles", 32'(ncyc), 32'd8);
    run_inst("store_timeout", 32'h0020_A023, 32'h0000_000C, 0, 1000, ncyc);
    chk("store_timeout cycles", 32'(ncyc), 32'd19);
    run_inst("branch", 32'h0020_8463, 32'h0000_0010, 0, 0, ncyc);
    chk("branch cycles", 32'(ncyc), 32'd3);
    chk("branch pc", pc, 32'h0000_0010);
    run_inst("halt5", 32'h0010_0093, 32'h0000_0014, 5, 0, ncyc);
    run_inst("load_ready_at_limit", 32'h0000_A103, 32'h0000_0018, 0, TIMEOUT, ncyc);
    run_inst("store_nowait", 32'h0020_A023, 32'hFFFF_FFFC, 0, 0, ncyc);
    chk("store_nowait cycles", 32'(ncyc), 32'd4);

    // Reset in the middle of a load's MEM phase.
    halt = 1'b0; inst = 32'h0000_A103; bus_ready = 1'b0; npc = $urandom; #1;
    chk("midmem fetch state", 32'(state), 32'd0);
    @(posedge cpu_clk); #1; model_ir = 32'h0000_A103;
    chk("midmem decode state", 32'(state), 32'd1);
    @(posedge cpu_clk); #1;
    chk("midmem exec state", 32'(state), 32'd2);
    @(posedge cpu_clk); #1;
    chk("midmem mem state", 32'(state), 32'd3);
    chk("midmem bus_req before", 32'(bus_req), 32'd1);
    #2 cpu_rst = 1'b1; #1;
    chk("midmem rst state", 32'(state), 32'd0);
    chk("midmem rst bus_req", 32'(bus_req), 32'd0);
    chk("midmem rst mdr_we", 32'(mdr_we), 32'd0);
    chk("midmem rst pc", pc, RST_PC);
    chk("midmem rst ir", ir, NOP_WORD);
    $display("[TB] midmem_reset state=%0d pc=%h ir=%h bus_req=%0d", state, pc, ir, bus_req);
    @(posedge cpu_clk); #1;
    cpu_rst = 1'b0; model_pc = RST_PC; model_ir = NOP_WORD;
    run_inst("after_reset", 32'h0010_0093, 32'h0000_0104, 0, 0, ncyc);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        do op = 7'($urandom);
        while (op_kind(op) != 0 || op == 7'b1100011 ? (op_kind(op) != 0) : 1'b0);
      end else begin
        op = ops[$urandom_range(0, 8)];
      end
      rinst = {$urandom} & 32'hFFFF_FF80;
      rinst[6:0] = op;
      run_inst($sformatf("rand%0d", n), rinst, $urandom, $urandom_range(0, 2),
               ($urandom_range(0, 3) == 0) ? $urandom_range(14, 20) : $urandom_range(0, 4),
               ncyc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
